fire_queue_multilane: RTL and testbench



---
 rtl/fire_queue_multilane_pkg.sv | 10 +
 rtl/fire_queue_multilane_compact.sv | 28 ++
 rtl/fire_queue_multilane.sv | 74 +++++++
 tb/tb_fire_queue_multilane.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/fire_queue_multilane_pkg.sv
// fire_queue_multilane_pkg: default sizing for the multilane fire queue
package fire_queue_multilane_pkg;
    localparam int DEF_TAGBITS    = 6;
    localparam int DEF_DEPTH_LOG2 = 6;
    localparam int DEF_LANES      = 4;
    localparam int DEF_DROPBITS   = 8;
    function automatic int depth_of(input int log2);
        return 1 << log2;
    endfunction
endpackage

// File: rtl/fire_queue_multilane_compact.sv
// fire_lane_compact: ascending-lane acceptance into available space with compacted write offsets
module fire_lane_compact #(
    parameter int LANES = 4,
    parameter int W     = 7
) (
    input  logic [LANES-1:0]       enq,
    input  logic [W-1:0]           space,
    output logic [LANES-1:0]       acc,
    output logic [LANES*(W-1)-1:0] offs,
    output logic [W-1:0]           n_acc,
    output logic [W-1:0]           n_drop
);
    logic [W-1:0] cnt, req;
    always_comb begin
        acc  = '0;
        offs = '0;
        cnt  = '0;
        req  = '0;
        for (int i = 0; i < LANES; i++) begin
            offs[i*(W-1) +: (W-1)] = cnt[W-2:0];
            acc[i] = enq[i] && (cnt < space);
            cnt = cnt + W'(acc[i]);
            req = req + W'(enq[i]);
        end
        n_acc  = cnt;
        n_drop = req - cnt;
    end
endmodule

// File: rtl/fire_queue_multilane.sv
// fire_queue_multilane: FWFT circular fire queue with parallel enqueue lanes and drop accounting
module fire_queue_multilane
    import fire_queue_multilane_pkg::*;
#(
    parameter int TAGBITS    = DEF_TAGBITS,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2,
    parameter int LANES      = DEF_LANES,
    parameter int DROPBITS   = DEF_DROPBITS
) (
    input  logic                     clk,
    input  logic                     asyn_reset,
    input  logic [LANES-1:0]         enq,
    input  logic [LANES*TAGBITS-1:0] in_tags,
    input  logic                     deq,
    input  logic                     clr_overflow,
    output logic [TAGBITS-1:0]       out_tag,
    output logic                     empty,
    output logic                     full,
    output logic [DEPTH_LOG2:0]      count,
    output logic                     overflow,
    output logic [DROPBITS-1:0]      drop_count
);
    localparam int DEPTH = depth_of(DEPTH_LOG2);
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int DW    = DROPBITS + CW;
    localparam logic [DROPBITS-1:0] DROP_MAX = '1;

    logic [TAGBITS-1:0]          mem [DEPTH];
    logic [DEPTH_LOG2-1:0]       rd_ptr, wr_ptr;
    logic                        deq_ok;
    logic [CW-1:0]               space, n_acc, n_drop;
    logic [LANES-1:0]            acc;
    logic [LANES*DEPTH_LOG2-1:0] offs;
    logic [DW-1:0]               drop_sum;

    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign deq_ok   = deq && !empty;
    assign space    = CW'(DEPTH) - count + CW'(deq_ok);
    assign out_tag  = empty ? '0 : mem[rd_ptr];
    assign drop_sum = DW'(drop_count) + DW'(n_drop);

    fire_lane_compact #(.LANES(LANES), .W(CW)) u_compact (
        .enq    (enq),
        .space  (space),
        .acc    (acc),
        .offs   (offs),
        .n_acc  (n_acc),
        .n_drop (n_drop)
    );

    always_ff @(posedge clk) begin
        for (int i = 0; i < LANES; i++)
            if (acc[i])
                mem[DEPTH_LOG2'(wr_ptr + offs[i*DEPTH_LOG2 +: DEPTH_LOG2])] <= in_tags[i*TAGBITS +: TAGBITS];
    end

    // a new drop wins over a simultaneous clear
    always_ff @(posedge clk or posedge asyn_reset) begin
        if (asyn_reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            rd_ptr     <= rd_ptr + DEPTH_LOG2'(deq_ok);
            wr_ptr     <= wr_ptr + n_acc[DEPTH_LOG2-1:0];
            count      <= count + n_acc - CW'(deq_ok);
            overflow   <= (n_drop != '0) || (overflow && !clr_overflow);
            drop_count <= drop_sum > DW'(DROP_MAX) ? DROP_MAX : drop_sum[DROPBITS-1:0];
        end
    end
endmodule

// File: tb/tb_fire_queue_multilane.sv
// tb_fire_queue_multilane: vector table plus queue scoreboard for the multilane fire queue
module tb_fire_queue_multilane;
    logic        clk = 1'b0;
    logic        asyn_reset;
    logic [3:0]  enq;
    logic [23:0] in_tags;
    logic        deq, clr_overflow;
    logic [5:0]  out_tag;
    logic        empty, full, overflow;
    logic [6:0]  count;
    logic [7:0]  drop_count;

    logic [3:0]  s_enq;
    logic [23:0] s_in_tags;
    logic        s_deq, s_clr;
    logic [5:0]  s_out_tag;
    logic        s_empty, s_full, s_ovf;
    logic [2:0]  s_count;
    logic [1:0]  s_drop;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0] m_q[$];
    logic       m_ovf;
    int         m_drop;

    typedef struct {
        logic [3:0]  e;
        logic [23:0] t;
        logic        d;
        logic        c;
        int          cnt;
        int          out;
    } vec_t;
    vec_t vt[4];

    always #5 clk = ~clk;

    fire_queue_multilane u_dut (
        .clk          (clk),
        .asyn_reset   (asyn_reset),
        .enq          (enq),
        .in_tags      (in_tags),
        .deq          (deq),
        .clr_overflow (clr_overflow),
        .out_tag      (out_tag),
        .empty        (empty),
        .full         (full),
        .count        (count),
        .overflow     (overflow),
        .drop_count   (drop_count)
    );

    fire_queue_multilane #(.DEPTH_LOG2(2), .DROPBITS(2)) u_sat (
        .clk          (clk),
        .asyn_reset   (asyn_reset),
        .enq          (s_enq),
        .in_tags      (s_in_tags),
        .deq          (s_deq),
        .clr_overflow (s_clr),
        .out_tag      (s_out_tag),
        .empty        (s_empty),
        .full         (s_full),
        .count        (s_count),
        .overflow     (s_ovf),
        .drop_count   (s_drop)
    );

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", n, act, exp);
        end
    endtask

    task automatic check_all();
        chk("count", 32'(count), 32'(m_q.size()));
        chk("empty", 32'(empty), 32'(m_q.size() == 0));
        chk("full", 32'(full), 32'(m_q.size() == 64));
        chk("out_tag", 32'(out_tag), m_q.size() > 0 ? 32'(m_q[0]) : 32'd0);
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
    endtask

    task automatic step(input logic [3:0] e, input logic [23:0] t, input logic d, input logic c);
        int  sp, na, nd;
        logic dok;
        @(negedge clk);
        enq = e; in_tags = t; deq = d; clr_overflow = c;
        dok = d && m_q.size() > 0;
        sp  = 64 - m_q.size() + int'(dok);
        if (dok) void'(m_q.pop_front());
        na = 0; nd = 0;
        for (int i = 0; i < 4; i++)
            if (e[i]) begin
                if (na < sp) begin
                    m_q.push_back(t[i*6 +: 6]);
                    na++;
                end else nd++;
            end
        if (nd > 0) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        m_drop = (m_drop + nd > 255) ? 255 : m_drop + nd;
        @(posedge clk);
        #1;
        enq = '0; deq = 1'b0; clr_overflow = 1'b0;
        check_all();
    endtask

    task automatic s_step(input logic [3:0] e, input logic c);
        @(negedge clk);
        s_enq = e; s_in_tags = {6'd14, 6'd13, 6'd12, 6'd11}; s_clr = c;
        @(posedge clk);
        #1;
        s_enq = '0; s_clr = 1'b0;
    endtask

    initial begin
        vt[0] = '{e: 4'b0101, t: {6'd0, 6'd9, 6'd0, 6'd5}, d: 1'b0, c: 1'b0, cnt: 2, out: 5};
        vt[1] = '{e: 4'b0000, t: 24'd0, d: 1'b1, c: 1'b0, cnt: 1, out: 9};
        vt[2] = '{e: 4'b0000, t: 24'd0, d: 1'b1, c: 1'b0, cnt: 0, out: 0};
        vt[3] = '{e: 4'b0000, t: 24'd0, d: 1'b1, c: 1'b0, cnt: 0, out: 0};

        asyn_reset = 1'b1;
        enq = '0; in_tags = '0; deq = 1'b0; clr_overflow = 1'b0;
        s_enq = '0; s_in_tags = '0; s_deq = 1'b0; s_clr = 1'b0;
        m_ovf = 1'b0; m_drop = 0;
        repeat (2) @(posedge clk);
        #1;
        check_all();
        chk("sat_reset_count", 32'(s_count), 0);
        @(negedge clk);
        asyn_reset = 1'b0;

        // small saturating instance: depth 4, 2-bit drop counter
        s_step(4'b1111, 1'b0);
        chk("sat_full", 32'(s_full), 1);
        chk("sat_head", 32'(s_out_tag), 11);
        s_step(4'b0001, 1'b0);
        chk("sat_ovf", 32'(s_ovf), 1);
        chk("sat_drop1", 32'(s_drop), 1);
        s_step(4'b1111, 1'b0);
        chk("sat_drop_sat", 32'(s_drop), 3);
        s_step(4'b0000, 1'b1);
        chk("sat_clr_ovf", 32'(s_ovf), 0);
        chk("sat_drop_kept", 32'(s_drop), 3);

        for (int i = 0; i < 4; i++) begin
            step(vt[i].e, vt[i].t, vt[i].d, vt[i].c);
            chk("vec_count", 32'(count), 32'(vt[i].cnt));
            chk("vec_out", 32'(out_tag), 32'(vt[i].out));
        end

        for (int i = 0; i < 64; i++) step(4'b0001, {18'd0, 6'(i)}, 1'b0, 1'b0);
        chk("fill_full", 32'(full), 1);
        step(4'b1111, {6'd4, 6'd3, 6'd2, 6'd1}, 1'b1, 1'b0);
        chk("ovf_count", 32'(count), 64);
        chk("ovf_flag", 32'(overflow), 1);
        chk("ovf_drops", 32'(drop_count), 3);
        step(4'b1111, {6'd8, 6'd7, 6'd6, 6'd5}, 1'b0, 1'b1);
        chk("set_beats_clr", 32'(overflow), 1);
        chk("drops_7", 32'(drop_count), 7);
        step(4'b0000, 24'd0, 1'b0, 1'b1);
        chk("clr_ovf", 32'(overflow), 0);
        chk("clr_keeps_drops", 32'(drop_count), 7);

        while (m_q.size() > 10) step(4'b0000, 24'd0, 1'b1, 1'b0);
        for (int k = 0; k < 50; k++) begin
            int a, b;
            a = $urandom_range(0, 3);
            b = (a + 1 + $urandom_range(0, 2)) % 4;
            step(4'((1 << a) | (1 << b)), 24'($urandom), 1'b1, 1'b0);
            step(4'b0000, 24'd0, 1'b1, 1'b0);
        end
        chk("wrap_count", 32'(count), 10);

        for (int i = 0; i < 7; i++) step(4'b0001, {18'd0, 6'(40 + i)}, 1'b0, 1'b0);
        chk("pre_reset_count", 32'(count), 17);

        @(negedge clk);
        asyn_reset = 1'b1;
        #1;
        chk("arst_count", 32'(count), 0);
        chk("arst_empty", 32'(empty), 1);
        chk("arst_out", 32'(out_tag), 0);
        chk("arst_drops", 32'(drop_count), 0);
        m_q.delete();
        m_ovf = 1'b0; m_drop = 0;
        @(negedge clk);
        asyn_reset = 1'b0;
        step(4'b0001, {18'd0, 6'd7}, 1'b0, 1'b0);
        chk("post_reset_out", 32'(out_tag), 7);
        chk("post_reset_count", 32'(count), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
